rv32i_psram_bridge: RTL
=======================

// Module: rv32i_psram_bridge
// PURPOSE
// - Data-side bridge between the rv32i MA stage and the 16-bit psram controller.
// - Converts one 32-bit byte/half/word load or store into one or two 16-bit psram beats.
// - Returns read data right-aligned and zero-extended; the core's reg_mask applies sign extension.
// - Flags misaligned requests.
// PARAMETERS
// - PSRAM_AW        22    psram halfword address width (byte addr bits [PSRAM_AW:1])
// - TIMEOUT_CYCLES  1024  watchdog limit per beat; used only with the optional feature
// PORTS
// - clk              in   1   core clock
// - reset_n          in   1   asynchronous, active-low reset
// - req_valid        in   1   request present
// - req_ready        out  1   bridge idle; request accepted when req_valid & req_ready
// - req_we           in   1   1 = store, 0 = load
// - req_size         in   2   0 = byte, 1 = half, 2 = word (3 treated as word)
// - req_addr         in   32  byte address
// - req_wdata        in   32  store data, right-aligned
// - rsp_valid        out  1   one-cycle completion pulse
// - rsp_rdata        out  32  load data; held until the next load completes
// - rsp_err          out  1   qualifies rsp_valid: misaligned access (or timeout)
// - ps_write_en      out  1   one-cycle psram write command
// - ps_read_en       out  1   one-cycle psram read command
// - ps_addr          out  PSRAM_AW  halfword address
// - ps_data_in       out  16  write data
// - ps_write_high_byte out 1  upper byte lane enable
// - ps_write_low_byte  out 1  lower byte lane enable
// - ps_busy          in   1   controller busy
// - ps_read_avail    in   1   read data valid pulse
// - ps_data_out      in   16  read data
// BEHAVIOUR
// - Reset: state IDLE, req_ready = 1, all other outputs 0. Reset is effective in any state.
//   An in-flight request is dropped with no rsp_valid; ps_* enables are deasserted immediately.
// - FSM: IDLE -> ISSUE -> WAIT -> (ISSUE for second beat | DONE) -> IDLE.
// - Accept (cycle 0): latch we, size, addr, wdata; set beat = 0.
//   - Misaligned (half with addr[0] = 1, or word with addr[1:0] != 0): go to DONE with err = 1; no ps_* activity.
// - ISSUE: wait for ps_busy == 0, then pulse ps_write_en or ps_read_en for exactly one cycle.
//   - ps_addr = addr[PSRAM_AW:1] + beat.
// - WAIT: ignore the first cycle after issue. Then:
//   - store: beat is done when ps_busy == 0.
//   - load: beat is done on ps_read_avail; capture ps_data_out into the beat slot.
// - Word access: beat 0 is the low half (wdata[15:0], rdata[15:0]); beat 1 is the high half.
//   Both byte lanes are enabled.
// - Half access: one beat, both lanes enabled, rdata = {16'b0, data}.
// - Byte access: one beat.
//   - ps_data_in = {wdata[7:0], wdata[7:0]}.
//   - addr[0] = 1: high lane only. addr[0] = 0: low lane only.
//   - Load returns {24'b0, addr[0] ? d[15:8] : d[7:0]}.
// - Beat-address arithmetic is PSRAM_AW bits and wraps modulo 2^PSRAM_AW.
// - DONE: rsp_valid = 1 for one cycle.
//   - rsp_rdata is updated only on a successful load.
//   - req_ready rises in the same cycle DONE exits to IDLE, so a back-to-back request is accepted
//     the cycle after rsp_valid.
// - Latency with no psram wait: 1-beat access = 5 cycles, accept to rsp_valid inclusive;
//   word = 8 cycles. A misaligned request completes with rsp_valid on cycle 1.
// - req_* inputs are don't-care while req_ready = 0.
// - ps_read_avail outside a read WAIT is ignored.
// CONFIGURATION
// - RV32I_PSRAM_BRIDGE_TIMEOUT_EN defined:
//   - Per-beat counter starts at ISSUE. If ISSUE+WAIT exceeds TIMEOUT_CYCLES, abort to DONE
//     with rsp_err = 1 and skip any remaining beat.
//   - Counter is cleared on each new beat and on reset.
// - RV32I_PSRAM_BRIDGE_TIMEOUT_EN undefined: no counter; the bridge waits indefinitely.
//   rsp_err is set only for misalignment.
// TESTING
// - Word store 0x8000_0010 = 0xDEADBEEF.
//   -> beat 0: ps_addr 0x000008, data 0xBEEF. Beat 1: ps_addr 0x000009, data 0xDEAD.
//   -> Both lanes on both beats; rsp_valid once, err 0.
// - Word load 0x8000_0010 with a model returning the above data -> rsp_rdata 0xDEADBEEF, 2 read_en pulses.
// - Byte store 0x8000_0013 = 0x000000AB -> one beat, ps_addr 0x000009, data 0xABAB, high lane only.
//   Byte load 0x8000_0013 -> rsp_rdata 0x000000AB.
// - Half load 0x8000_0011 and word load 0x8000_0012 -> rsp_valid with rsp_err = 1 on cycle 1;
//   no ps_read_en; rsp_rdata unchanged.
// - ps_busy held high 20 cycles at ISSUE -> no enable pulse until busy falls.
//   Then deassert reset_n during WAIT -> all outputs 0 asynchronously, req_ready = 1 after release,
//   no rsp_valid.
// - TIMEOUT_EN with TIMEOUT_CYCLES = 16 and a word load with ps_read_avail never asserted
//   -> rsp_err = 1 after 16 cycles, no beat-1 issue.

Source files
------------

// File: rtl/rv32i_psram_bridge.sv
// rv32i_psram_bridge
// Data-side bridge from the rv32i MA stage to a 16-bit psram controller.
// Splits each byte/half/word load or store into one or two 16-bit psram beats,
// returns load data right-aligned and zero-extended, and flags misaligned requests.
//
// Optional feature: define RV32I_PSRAM_BRIDGE_TIMEOUT_EN to enable a per-beat
// watchdog (TIMEOUT_CYCLES) that aborts a stuck access with rsp_err = 1.
//
// Ports
//   clk, reset_n            core clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready = bridge idle)
//   req_we/size/addr/wdata  request payload (size 0 byte, 1 half, 2/3 word)
//   rsp_valid/rdata/err     one-cycle completion pulse, held load data, error flag
//   ps_write_en/ps_read_en  one-cycle psram commands
//   ps_addr/ps_data_in      psram halfword address and write data
//   ps_write_high/low_byte  byte lane enables
//   ps_busy/ps_read_avail   controller status, read data strobe
//   ps_data_out             psram read data
module rv32i_psram_bridge #(
  parameter int unsigned PSRAM_AW       = 22,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic                ps_write_en,
  output logic                ps_read_en,
  output logic [PSRAM_AW-1:0] ps_addr,
  output logic [15:0]         ps_data_in,
  output logic                ps_write_high_byte,
  output logic                ps_write_low_byte,
  input  logic                ps_busy,
  input  logic                ps_read_avail,
  input  logic [15:0]         ps_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_we, w_we_nxt;
  logic [1:0]            r_size, w_size_nxt;
  logic [PSRAM_AW:0]     r_addr, w_addr_nxt;
  logic [31:0]           r_wdata, w_wdata_nxt;
  logic                  r_beat, w_beat_nxt;
  logic                  r_skip, w_skip_nxt;
  logic [15:0]           r_lo_half, w_lo_half_nxt;
  logic                  r_req_ready, w_req_ready_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic [31:0]           r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_ps_wr, w_ps_wr_nxt;
  logic                  r_ps_rd, w_ps_rd_nxt;
  logic [PSRAM_AW-1:0]   r_ps_addr, w_ps_addr_nxt;
  logic [15:0]           r_ps_din, w_ps_din_nxt;
  logic                  r_ps_hi, w_ps_hi_nxt;
  logic                  r_ps_lo, w_ps_lo_nxt;

  // Beat setup source: the live request while idle, otherwise the latched one (second beat)
  logic [1:0]            w_src_size;
  logic [PSRAM_AW:0]     w_src_addr;
  logic [31:0]           w_src_wdata;
  logic                  w_src_beat;
  logic [PSRAM_AW-1:0]   w_beat_addr;
  logic [15:0]           w_beat_data;
  logic                  w_beat_hi;
  logic                  w_beat_lo;
  logic                  w_misaligned;
  logic                  w_last_beat;
  logic                  w_beat_done;
  logic [31:0]           w_load_data;
  logic                  w_tmo_hit;

  assign w_src_size  = (r_state == S_IDLE) ? req_size : r_size;
  assign w_src_addr  = (r_state == S_IDLE) ? req_addr[PSRAM_AW:0] : r_addr;
  assign w_src_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_src_beat  = (r_state != S_IDLE);
  assign w_beat_addr = w_src_addr[PSRAM_AW:1] + PSRAM_AW'(w_src_beat);

  // Lane/data mapping: byte replicates into both lanes, word picks half by beat
  always_comb begin
    w_beat_hi   = 1'b1;
    w_beat_lo   = 1'b1;
    w_beat_data = w_src_wdata[15:0];
    case (w_src_size)
      2'd0: begin
        w_beat_data = {w_src_wdata[7:0], w_src_wdata[7:0]};
        w_beat_hi   = w_src_addr[0];
        w_beat_lo   = ~w_src_addr[0];
      end
      2'd1:    w_beat_data = w_src_wdata[15:0];
      default: w_beat_data = w_src_beat ? w_src_wdata[31:16] : w_src_wdata[15:0];
    endcase
  end

  assign w_misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
  assign w_last_beat  = ~r_size[1] | r_beat;
  assign w_beat_done  = r_we ? ~ps_busy : ps_read_avail;

  // Final-beat load result, zero-extended
  always_comb begin
    case (r_size)
      2'd0:    w_load_data = {24'h0, r_addr[0] ? ps_data_out[15:8] : ps_data_out[7:0]};
      2'd1:    w_load_data = {16'h0, ps_data_out};
      default: w_load_data = {ps_data_out, r_lo_half};
    endcase
  end

`ifdef RV32I_PSRAM_BRIDGE_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;

  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES));

  // Counts cycles spent in ISSUE+WAIT for the current beat; restarts on each new beat
  always_comb begin
    w_tmo_nxt = '0;
    if ((w_state_nxt == S_WAIT) || ((w_state_nxt == S_ISSUE) && (r_state == S_ISSUE)))
      w_tmo_nxt = r_tmo + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_tmo <= '0;
    else          r_tmo <= w_tmo_nxt;
  end
`else
  assign w_tmo_hit = 1'b0;
  // Watchdog limit has no effect without the watchdog
  logic w_unused_tmo;
  assign w_unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_we_nxt        = r_we;
    w_size_nxt      = r_size;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_beat_nxt      = r_beat;
    w_skip_nxt      = r_skip;
    w_lo_half_nxt   = r_lo_half;
    w_req_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_ps_wr_nxt     = 1'b0;
    w_ps_rd_nxt     = 1'b0;
    w_ps_addr_nxt   = r_ps_addr;
    w_ps_din_nxt    = r_ps_din;
    w_ps_hi_nxt     = r_ps_hi;
    w_ps_lo_nxt     = r_ps_lo;

    unique case (r_state)
      S_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (req_valid && r_req_ready) begin
          w_we_nxt        = req_we;
          w_size_nxt      = req_size;
          w_addr_nxt      = req_addr[PSRAM_AW:0];
          w_wdata_nxt     = req_wdata;
          w_beat_nxt      = 1'b0;
          w_req_ready_nxt = 1'b0;
          if (w_misaligned) begin
            w_state_nxt     = S_DONE;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end else begin
            w_state_nxt   = S_ISSUE;
            w_ps_addr_nxt = w_beat_addr;
            w_ps_din_nxt  = w_beat_data;
            w_ps_hi_nxt   = w_beat_hi;
            w_ps_lo_nxt   = w_beat_lo;
          end
        end
      end
      S_ISSUE: begin
        if (w_tmo_hit) begin
          w_state_nxt     = S_DONE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
        end else if (!ps_busy) begin
          w_ps_wr_nxt = r_we;
          w_ps_rd_nxt = ~r_we;
          w_skip_nxt  = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // First WAIT cycle is ignored: the controller has not yet seen the command
        if (w_tmo_hit) begin
          w_state_nxt     = S_DONE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
        end else if (r_skip) begin
          w_skip_nxt = 1'b0;
        end else if (w_beat_done) begin
          if (!r_we && !r_beat) w_lo_half_nxt = ps_data_out;
          if (w_last_beat) begin
            w_state_nxt     = S_DONE;
            w_rsp_valid_nxt = 1'b1;
            if (!r_we) w_rsp_rdata_nxt = w_load_data;
          end else begin
            w_beat_nxt    = 1'b1;
            w_state_nxt   = S_ISSUE;
            w_ps_addr_nxt = w_beat_addr;
            w_ps_din_nxt  = w_beat_data;
            w_ps_hi_nxt   = w_beat_hi;
            w_ps_lo_nxt   = w_beat_lo;
          end
        end
      end
      S_DONE: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_size      <= 2'd0;
      r_addr      <= '0;
      r_wdata     <= 32'h0;
      r_beat      <= 1'b0;
      r_skip      <= 1'b0;
      r_lo_half   <= 16'h0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_ps_wr     <= 1'b0;
      r_ps_rd     <= 1'b0;
      r_ps_addr   <= '0;
      r_ps_din    <= 16'h0;
      r_ps_hi     <= 1'b0;
      r_ps_lo     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_we        <= w_we_nxt;
      r_size      <= w_size_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_beat      <= w_beat_nxt;
      r_skip      <= w_skip_nxt;
      r_lo_half   <= w_lo_half_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_ps_wr     <= w_ps_wr_nxt;
      r_ps_rd     <= w_ps_rd_nxt;
      r_ps_addr   <= w_ps_addr_nxt;
      r_ps_din    <= w_ps_din_nxt;
      r_ps_hi     <= w_ps_hi_nxt;
      r_ps_lo     <= w_ps_lo_nxt;
    end
  end

  // Address bits above the psram window are ignored
  logic w_unused_addr;
  assign w_unused_addr = ^req_addr[31:PSRAM_AW+1];

  assign req_ready          = r_req_ready;
  assign rsp_valid          = r_rsp_valid;
  assign rsp_err            = r_rsp_err;
  assign rsp_rdata          = r_rsp_rdata;
  assign ps_write_en        = r_ps_wr;
  assign ps_read_en         = r_ps_rd;
  assign ps_addr            = r_ps_addr;
  assign ps_data_in         = r_ps_din;
  assign ps_write_high_byte = r_ps_hi;
  assign ps_write_low_byte  = r_ps_lo;

endmodule
